// File: rtl/difftest_commit_sequencer_if.sv
// Commit-sequencer bus: multi-lane commit records in, one BasicInstrCommit record out.
//   master (commit stage + difftest sink side): drives coreid, flush, in_valid/in_bits, out_ready
//   slave  (sequencer): drives in_ready and all io_out_* signals
interface difftest_commit_sequencer_if #(
  parameter int unsigned LANES = 2
);
  logic [7:0]          io_coreid;
  logic                io_flush;
  logic [LANES-1:0]    io_in_valid;
  logic [52*LANES-1:0] io_in_bits;
  logic                io_in_ready;
  logic                io_out_valid;
  logic                io_out_ready;
  logic [7:0]          io_out_coreid;
  logic [7:0]          io_out_index;
  logic [7:0]          io_out_special;
  logic [7:0]          io_out_wdest;
  logic                io_out_skip;
  logic                io_out_isRVC;
  logic                io_out_rfwen;
  logic                io_out_fpwen;
  logic [31:0]         io_out_wpdest;

  modport master (
    output io_coreid, io_flush, io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_coreid, io_out_index, io_out_special,
           io_out_wdest, io_out_skip, io_out_isRVC, io_out_rfwen, io_out_fpwen, io_out_wpdest
  );

  modport slave (
    input  io_coreid, io_flush, io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_coreid, io_out_index, io_out_special,
           io_out_wdest, io_out_skip, io_out_isRVC, io_out_rfwen, io_out_fpwen, io_out_wpdest
  );
endinterface

// File: rtl/difftest_commit_sequencer.sv
// Buffers up to LANES commit records per cycle in order and replays them one per cycle
// to a difftest BasicInstrCommit sink, numbering them with a wrapping 8-bit sequence.
// Ports:
//   io_clock, io_reset : clock, asynchronous active-high reset
//   bus (slave)        : commit lanes in (valid/bits/ready), flush, coreid, single record out
// Optional feature (macro DIFFTEST_COMMIT_STATS_EN):
//   io_stat_commits    : saturating count of dequeued records
//   io_stat_stalls     : saturating count of cycles with lanes valid while not ready
module difftest_commit_sequencer #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic io_clock,
  input  logic io_reset,
  difftest_commit_sequencer_if.slave bus
`ifdef DIFFTEST_COMMIT_STATS_EN
  ,
  output logic [31:0] io_stat_commits,
  output logic [31:0] io_stat_stalls
`endif
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 52;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - LANES);

  typedef struct packed {
    logic [7:0]  special;
    logic        skip;
    logic        is_rvc;
    logic        rfwen;
    logic        fpwen;
    logic [31:0] wpdest;
    logic [7:0]  wdest;
  } rec_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_BACKPRESSURE} state_t;

  rec_t          mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, pop_c;
  logic [7:0]    seq_q, seq_d;
  state_t        state_q, state_d;
  logic          enq_c, deq_c;
  logic [LANES-1:0] wr_en_c;
  logic [AW-1:0] wr_idx_c [LANES];
  rec_t          head_rec_c;

  // Ready looks only at registered occupancy so the sink can't combinationally gate the source.
  assign bus.io_in_ready  = (count_q <= READY_MAX);
  assign bus.io_out_valid = (count_q != '0);
  assign enq_c = bus.io_in_ready;
  assign deq_c = bus.io_out_valid & bus.io_out_ready;

  // Next-state: lane compaction, pointer/count/sequence update, occupancy state.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    seq_d    = seq_q;
    state_d  = state_q;
    pop_c    = '0;
    wr_en_c  = '0;
    for (int k = 0; k < LANES; k++) wr_idx_c[k] = '0;

    // Each valid lane lands at tail + (number of valid lanes below it).
    for (int k = 0; k < LANES; k++) begin
      if (bus.io_in_valid[k]) begin
        wr_idx_c[k] = tail_q + AW'(pop_c);
        wr_en_c[k]  = enq_c & ~bus.io_flush;
        pop_c       = pop_c + CW'(1);
      end
    end

    if (bus.io_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      seq_d   = '0;
    end else begin
      if (enq_c) begin
        tail_d  = tail_q + AW'(pop_c);
        count_d = count_d + pop_c;
      end
      if (deq_c) begin
        head_d  = head_q + AW'(1);
        seq_d   = seq_q + 8'd1;
        count_d = count_d - CW'(1);
      end
    end

    if (count_d == '0)           state_d = ST_EMPTY;
    else if (count_d > READY_MAX) state_d = ST_BACKPRESSURE;
    else                          state_d = ST_ACTIVE;
  end

  // Control state register.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      state_q <= ST_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      state_q <= state_d;
    end
  end

  // Record storage; contents need no reset because out fields are masked while empty.
  always_ff @(posedge io_clock) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en_c[k]) mem_q[wr_idx_c[k]] <= rec_t'(bus.io_in_bits[RW*k +: RW]);
    end
  end

  // Output record: head entry when valid, zeros otherwise (coreid always passes through).
  assign head_rec_c = mem_q[head_q];
  always_comb begin
    bus.io_out_coreid  = bus.io_coreid;
    bus.io_out_index   = '0;
    bus.io_out_special = '0;
    bus.io_out_wdest   = '0;
    bus.io_out_skip    = 1'b0;
    bus.io_out_isRVC   = 1'b0;
    bus.io_out_rfwen   = 1'b0;
    bus.io_out_fpwen   = 1'b0;
    bus.io_out_wpdest  = '0;
    if (bus.io_out_valid) begin
      bus.io_out_index   = seq_q;
      bus.io_out_special = head_rec_c.special;
      bus.io_out_wdest   = head_rec_c.wdest;
      bus.io_out_skip    = head_rec_c.skip;
      bus.io_out_isRVC   = head_rec_c.is_rvc;
      bus.io_out_rfwen   = head_rec_c.rfwen;
      bus.io_out_fpwen   = head_rec_c.fpwen;
      bus.io_out_wpdest  = head_rec_c.wpdest;
    end
  end

  // Occupancy invariants: never overfull, backpressure state tracks the ready threshold.
  always_ff @(posedge io_clock) begin
    if (!io_reset) begin
      assert (count_q <= CW'(DEPTH));
      assert ((state_q == ST_BACKPRESSURE) == (count_q > READY_MAX));
    end
  end

`ifdef DIFFTEST_COMMIT_STATS_EN
  logic [31:0] commits_q, stalls_q;

  // Saturating statistics; flush leaves them alone.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      commits_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (deq_c && !bus.io_flush && (commits_q != '1)) commits_q <= commits_q + 32'd1;
      if ((|bus.io_in_valid) && !bus.io_in_ready && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign io_stat_commits = commits_q;
  assign io_stat_stalls  = stalls_q;
`endif
endmodule

// File: tb/tb_difftest_commit_sequencer.sv
// Self-checking bench for difftest_commit_sequencer: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a queue model.
module tb_difftest_commit_sequencer;
  localparam int unsigned L  = 2;
  localparam int unsigned D  = 8;
  localparam int unsigned BW = 52 * L;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  difftest_commit_sequencer_if #(.LANES(L)) bus();

`ifdef DIFFTEST_COMMIT_STATS_EN
  logic [31:0] stat_commits, stat_stalls;
`endif

  difftest_commit_sequencer #(.LANES(L), .DEPTH(D)) dut (
    .io_clock (clk),
    .io_reset (rst),
    .bus      (bus)
`ifdef DIFFTEST_COMMIT_STATS_EN
    ,
    .io_stat_commits (stat_commits),
    .io_stat_stalls  (stat_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: FIFO of 52-bit records, sequence number, stats.
  logic [51:0]     mq[$];
  int unsigned     mseq = 0;
  longint unsigned m_commits = 0;
  longint unsigned m_stalls  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [51:0] mk(input logic [7:0] wdest, input logic [31:0] wpdest);
    return {wdest ^ 8'h5A, 1'b0, wdest[0], 1'b1, wdest[1], wpdest, wdest};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.io_in_valid = '0;
    bus.io_flush = 1'b0;
    step();
    rst = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mseq = 0;
      m_commits = 0;
      m_stalls = 0;
    end else begin
      bit rdy;
      rdy = (mq.size() <= D - L);
      if ((|bus.io_in_valid) && !rdy) m_stalls++;
      if (bus.io_flush) begin
        mq.delete();
        mseq = 0;
      end else begin
        if (mq.size() != 0 && bus.io_out_ready) begin
          void'(mq.pop_front());
          mseq = (mseq + 1) % 256;
          m_commits++;
        end
        if (rdy)
          for (int k = 0; k < L; k++)
            if (bus.io_in_valid[k]) mq.push_back(bus.io_in_bits[52*k +: 52]);
      end
    end
  end

  task automatic compare_all();
    logic [51:0] r;
    bit v;
    v = (mq.size() != 0);
    r = v ? mq[0] : 52'd0;
    chk("m_in_ready", 64'(bus.io_in_ready), 64'(mq.size() <= D - L));
    chk("m_out_valid", 64'(bus.io_out_valid), 64'(v));
    chk("m_coreid", 64'(bus.io_out_coreid), 64'(bus.io_coreid));
    chk("m_index", 64'(bus.io_out_index), v ? 64'(mseq % 256) : 64'd0);
    chk("m_fields", 64'({bus.io_out_special, bus.io_out_skip, bus.io_out_isRVC, bus.io_out_rfwen,
                         bus.io_out_fpwen, bus.io_out_wpdest, bus.io_out_wdest}), 64'(r));
`ifdef DIFFTEST_COMMIT_STATS_EN
    chk("m_stat_commits", 64'(stat_commits), m_commits);
    chk("m_stat_stalls", 64'(stat_stalls), m_stalls);
`endif
  endtask

  always @(negedge clk) if (!rst && cmp_en) compare_all();

  initial begin
    logic [127:0] rnd;
    int thresh;
    bus.io_coreid    = 8'h3C;
    bus.io_flush     = 1'b0;
    bus.io_in_valid  = '0;
    bus.io_in_bits   = '0;
    bus.io_out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_in_ready", 64'(bus.io_in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.io_out_valid), 64'd0);
    chk("rst_wdest", 64'(bus.io_out_wdest), 64'd0);
    chk("rst_index", 64'(bus.io_out_index), 64'd0);
    chk("rst_coreid", 64'(bus.io_out_coreid), 64'h3C);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Two lanes, drained in lane order
    bus.io_in_valid  = 2'b11;
    bus.io_in_bits   = {mk(8'd6, 32'h66), mk(8'd5, 32'h55)};
    bus.io_out_ready = 1'b1;
    step();
    bus.io_in_valid = '0;
    chk("t1_valid0", 64'(bus.io_out_valid), 64'd1);
    chk("t1_wdest0", 64'(bus.io_out_wdest), 64'd5);
    chk("t1_index0", 64'(bus.io_out_index), 64'd0);
    step();
    chk("t1_wdest1", 64'(bus.io_out_wdest), 64'd6);
    chk("t1_index1", 64'(bus.io_out_index), 64'd1);
    step();
    chk("t1_empty", 64'(bus.io_out_valid), 64'd0);

    // Only lane 1 valid
    do_reset();
    bus.io_in_valid  = 2'b10;
    bus.io_in_bits   = {mk(8'h22, 32'h1234), mk(8'h11, 32'hDEAD)};
    bus.io_out_ready = 1'b1;
    step();
    bus.io_in_valid = '0;
    chk("t2_valid", 64'(bus.io_out_valid), 64'd1);
    chk("t2_wpdest", 64'(bus.io_out_wpdest), 64'h1234);
    chk("t2_wdest", 64'(bus.io_out_wdest), 64'h22);
    chk("t2_index", 64'(bus.io_out_index), 64'd0);
    step();
    chk("t2_empty", 64'(bus.io_out_valid), 64'd0);

    // Backpressure with a stalled sink, then in-order release
    do_reset();
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.io_in_valid = 2'b11;
      bus.io_in_bits  = {mk(8'(2*i+1), 32'(100+2*i+1)), mk(8'(2*i), 32'(100+2*i))};
      step();
      if (i == 2) chk("t3_ready_at6", 64'(bus.io_in_ready), 64'd1);
      if (i == 3) chk("t3_ready_at8", 64'(bus.io_in_ready), 64'd0);
    end
    bus.io_in_valid  = '0;
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_wdest", 64'(bus.io_out_wdest), 64'(i));
      chk("t3_index", 64'(bus.io_out_index), 64'(i));
      step();
      if (i == 0) chk("t3_ready_at7", 64'(bus.io_in_ready), 64'd0);
      if (i == 1) chk("t3_ready_rise", 64'(bus.io_in_ready), 64'd1);
    end
    chk("t3_drained", 64'(bus.io_out_valid), 64'd0);

    // Sequence number wrap
    do_reset();
    bus.io_out_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      bus.io_in_valid = 2'b01;
      bus.io_in_bits  = {52'd0, mk(8'(i), 32'(i))};
      step();
      if (i == 256) chk("t4_index255", 64'(bus.io_out_index), 64'd255);
      if (i == 257) chk("t4_index0", 64'(bus.io_out_index), 64'd0);
    end
    bus.io_in_valid = '0;
    step();
    step();

    // Flush with count 5 and a same-cycle enqueue
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 2'b11;
    bus.io_in_bits   = {mk(8'h41, 32'h1), mk(8'h40, 32'h0)};
    step();
    step();
    bus.io_in_valid = 2'b01;
    step();
    bus.io_in_valid = 2'b11;
    bus.io_flush    = 1'b1;
    step();
    bus.io_flush    = 1'b0;
    bus.io_in_valid = '0;
    chk("t5_valid", 64'(bus.io_out_valid), 64'd0);
    chk("t5_ready", 64'(bus.io_in_ready), 64'd1);
    bus.io_in_valid  = 2'b01;
    bus.io_in_bits   = {52'd0, mk(8'h77, 32'h7777)};
    bus.io_out_ready = 1'b1;
    step();
    bus.io_in_valid = '0;
    chk("t5_next_valid", 64'(bus.io_out_valid), 64'd1);
    chk("t5_next_index", 64'(bus.io_out_index), 64'd0);
    chk("t5_next_wdest", 64'(bus.io_out_wdest), 64'h77);
    step();

    // Asynchronous reset with three records buffered
    bus.io_out_ready = 1'b0;
    bus.io_in_valid  = 2'b11;
    bus.io_in_bits   = {mk(8'h91, 32'h91), mk(8'h90, 32'h90)};
    step();
    bus.io_in_valid = 2'b01;
    step();
    bus.io_in_valid = '0;
    chk("t6_pre_valid", 64'(bus.io_out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(bus.io_out_valid), 64'd0);
    chk("t6_wdest", 64'(bus.io_out_wdest), 64'd0);
    chk("t6_ready", 64'(bus.io_in_ready), 64'd1);
`ifdef DIFFTEST_COMMIT_STATS_EN
    chk("t6_stat_commits", 64'(stat_commits), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic, checked every cycle by the model
    thresh = 80;
    for (int n = 0; n < 4000; n++) begin
      if (n % 400 == 0) thresh = $urandom_range(10, 100);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      bus.io_in_valid  = L'($urandom);
      bus.io_in_bits   = rnd[BW-1:0];
      bus.io_coreid    = 8'($urandom);
      bus.io_out_ready = ($urandom_range(0, 99) < thresh);
      bus.io_flush     = ($urandom_range(0, 63) == 0);
      step();
    end
    bus.io_in_valid = '0;
    bus.io_flush    = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
